// File: rtl/spw_rx_fifo_pkg.sv
// Shared SpaceWire receive-path types and constants: N-Char width,
// end-of-packet marker encodings and the {flag, data} character struct.
package spw_pkg;

  localparam int SPW_CHAR_W = 9;

  localparam logic [SPW_CHAR_W-1:0] SPW_EOP = 9'h100;
  localparam logic [SPW_CHAR_W-1:0] SPW_EEP = 9'h101;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } spw_char_t;

endpackage : spw_pkg

// File: rtl/spw_rx_fifo_mem.sv
// Simple dual-port character RAM: synchronous write, registered synchronous
// read. A read of the address being written returns the old contents, which
// the FIFO relies on when it is full and reads/writes the same slot.
module spw_rx_fifo_mem
  import spw_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [SPW_CHAR_W-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [SPW_CHAR_W-1:0] o_rdata
);

  logic [SPW_CHAR_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [SPW_CHAR_W-1:0] r_rdata;

  // Store one character per accepted write; contents are not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register loads only on a read and otherwise holds the last value.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_rdata <= {SPW_CHAR_W{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : spw_rx_fifo_mem

// File: rtl/spw_rx_fifo.sv
// SpaceWire receive character FIFO between the codec and CPU PIO ports.
// Pointers, occupancy and registered status (empty/full/room/overflow).
// Optional feature macro: SPW_RX_FIFO_DROP_CNT_EN adds a 16-bit saturating
// count of characters dropped while full (port drop_cnt).
module spw_rx_fifo
  import spw_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int ROOM_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic                  rx_flag,
  input  logic [7:0]            rx_data,
  input  logic                  rd_req,
  output logic [SPW_CHAR_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rx_empty,
  output logic                  rx_full,
  output logic [ROOM_W-1:0]     rxroom,
`ifdef SPW_RX_FIFO_DROP_CNT_EN
  output logic [15:0]           drop_cnt,
`endif
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int                  DEPTH     = 2**DEPTH_LOG2;
  localparam int                  ROOM_MAX  = 2**ROOM_W - 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [ROOM_W-1:0]   ROOM_RST  =
    (DEPTH > ROOM_MAX) ? ROOM_W'(ROOM_MAX) : ROOM_W'(DEPTH);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_rd_valid;
  logic                  r_empty;
  logic                  r_full;
  logic [ROOM_W-1:0]     r_room;
  logic                  r_overflow;

  logic                  w_full_now;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [31:0]           w_free;
  logic [ROOM_W-1:0]     w_room_nxt;
  spw_char_t             w_wchar;

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  assign w_full_now = (r_count == DEPTH_CNT);
  assign w_rd_acc   = rd_req && (r_count != {(DEPTH_LOG2+1){1'b0}});
  assign w_wr_acc   = rx_valid && (!w_full_now || w_rd_acc);
  assign w_drop     = rx_valid && w_full_now && !w_rd_acc;
  assign w_wchar    = '{flag: rx_flag, data: rx_data};

  // Next-state occupancy; simultaneous read and write leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Free space from the next-state count, saturated to the rxroom width.
  always_comb begin
    w_free = 32'(DEPTH) - 32'(w_count_nxt);
    if (w_free > 32'(ROOM_MAX)) begin
      w_room_nxt = ROOM_W'(ROOM_MAX);
    end else begin
      w_room_nxt = w_free[ROOM_W-1:0];
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr   <= {DEPTH_LOG2{1'b0}};
      r_count    <= {(DEPTH_LOG2+1){1'b0}};
      r_rd_valid <= 1'b0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_room     <= ROOM_RST;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      r_count    <= w_count_nxt;
      r_rd_valid <= w_rd_acc;
      r_empty    <= (w_count_nxt == {(DEPTH_LOG2+1){1'b0}});
      r_full     <= (w_count_nxt == DEPTH_CNT);
      r_room     <= w_room_nxt;
    end
  end

  // Sticky overflow; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef SPW_RX_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating drop counter; a clear coinciding with a drop restarts at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 16'h0000;
    end else if (ovf_clr) begin
      r_drop_cnt <= w_drop ? 16'h0001 : 16'h0000;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  spw_rx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_reset (reset),
    .i_we    (w_wr_acc && !reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wchar),
    .i_re    (w_rd_acc && !reset),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign rd_valid = r_rd_valid;
  assign rx_empty = r_empty;
  assign rx_full  = r_full;
  assign rxroom   = r_room;
  assign overflow = r_overflow;

endmodule : spw_rx_fifo

// File: tb/tb_spw_rx_fifo.sv
// Directed testbench for spw_rx_fifo (default 64-entry, 6-bit rxroom).
module tb_spw_rx_fifo;
  import spw_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic        rd_req;
  logic [8:0]  rd_data;
  logic        rd_valid;
  logic        rx_empty;
  logic        rx_full;
  logic [5:0]  rxroom;
  logic        overflow;
  logic        ovf_clr;
`ifdef SPW_RX_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spw_rx_fifo #(.DEPTH_LOG2(6), .ROOM_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_flag  (rx_flag),
    .rx_data  (rx_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .rxroom   (rxroom),
`ifdef SPW_RX_FIFO_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_flag = 1'b0; rx_data = 8'h00;
    rd_req = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_rd_data", 32'(rd_data), 32'h000);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_empty", 32'(rx_empty), 32'd1);
    chk("rst_full", 32'(rx_full), 32'd0);
    chk("rst_room", 32'(rxroom), 32'd63);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef SPW_RX_FIFO_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("idle_empty", 32'(rx_empty), 32'd1);

    // Three writes: 'A', 'B', EOP
    rx_valid = 1'b1; rx_flag = 1'b0; rx_data = 8'h41;
    tick();
    chk("wr1_empty", 32'(rx_empty), 32'd0);
    chk("wr1_room", 32'(rxroom), 32'd63);
    rx_data = 8'h42;
    tick();
    chk("wr2_room", 32'(rxroom), 32'd62);
    rx_flag = 1'b1; rx_data = 8'h00;
    tick();
    chk("wr3_room", 32'(rxroom), 32'd61);
    rx_valid = 1'b0; rx_flag = 1'b0;

    // Three back-to-back pops
    rd_req = 1'b1;
    tick();
    chk("pop1_valid", 32'(rd_valid), 32'd1);
    chk("pop1_data", 32'(rd_data), 32'h041);
    chk("pop1_empty", 32'(rx_empty), 32'd0);
    tick();
    chk("pop2_valid", 32'(rd_valid), 32'd1);
    chk("pop2_data", 32'(rd_data), 32'h042);
    tick();
    chk("pop3_valid", 32'(rd_valid), 32'd1);
    chk("pop3_data", 32'(rd_data), 32'(SPW_EOP));
    chk("pop3_empty", 32'(rx_empty), 32'd1);
    chk("pop3_room", 32'(rxroom), 32'd63);
    rd_req = 1'b0;
    tick();
    chk("pop_done_valid", 32'(rd_valid), 32'd0);

    // Fill with 64 writes of 0..63
    rx_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rx_data = 8'(i);
      tick();
      if (i == 62) begin
        chk("fill63_room", 32'(rxroom), 32'd1);
        chk("fill63_full", 32'(rx_full), 32'd0);
      end
    end
    chk("fill_full", 32'(rx_full), 32'd1);
    chk("fill_room", 32'(rxroom), 32'd0);
    chk("fill_ovf", 32'(overflow), 32'd0);
    // 65th write is dropped
    rx_data = 8'hFF;
    tick();
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_full", 32'(rx_full), 32'd1);
    chk("drop_room", 32'(rxroom), 32'd0);
`ifdef SPW_RX_FIFO_DROP_CNT_EN
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
    rx_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    chk("clr_ovf", 32'(overflow), 32'd0);
`ifdef SPW_RX_FIFO_DROP_CNT_EN
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    ovf_clr = 1'b0;

    // Full: simultaneous read and write
    rx_valid = 1'b1; rx_data = 8'hAA; rd_req = 1'b1;
    tick();
    chk("rw_full_valid", 32'(rd_valid), 32'd1);
    chk("rw_full_data", 32'(rd_data), 32'h000);
    chk("rw_full_full", 32'(rx_full), 32'd1);
    chk("rw_full_room", 32'(rxroom), 32'd0);
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    rx_valid = 1'b0;

    // Drain: 1..63 then 0xAA (0xFF never stored)
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("drain_data", 32'(rd_data), (i == 64) ? 32'h0AA : 32'(i));
    end
    chk("drain_empty", 32'(rx_empty), 32'd1);
    tick();
    // rd_req still high while empty: ignored
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("empty_rd_data", 32'(rd_data), 32'h0AA);

    // Read and write while empty: no fall-through
    rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    chk("nofall_valid", 32'(rd_valid), 32'd0);
    chk("nofall_data", 32'(rd_data), 32'h0AA);
    chk("nofall_empty", 32'(rx_empty), 32'd0);
    chk("nofall_room", 32'(rxroom), 32'd63);
    rd_req = 1'b0;

    // Refill to 64, drop once, then drop together with ovf_clr
    for (int i = 0; i < 63; i++) begin
      rx_data = 8'(i);
      tick();
    end
    chk("refill_full", 32'(rx_full), 32'd1);
    tick();
    chk("drop2_ovf", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    chk("set_wins_ovf", 32'(overflow), 32'd1);
`ifdef SPW_RX_FIFO_DROP_CNT_EN
    chk("set_wins_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    rx_valid = 1'b0;
    tick();
    chk("clr2_ovf", 32'(overflow), 32'd0);
    ovf_clr = 1'b0;

    // Reset to empty (with a coinciding read/write that must be ignored)
    reset = 1'b1; rx_valid = 1'b1; rd_req = 1'b1; rx_data = 8'h77;
    tick();
    chk("rst2_empty", 32'(rx_empty), 32'd1);
    chk("rst2_valid", 32'(rd_valid), 32'd0);
    chk("rst2_full", 32'(rx_full), 32'd0);
    reset = 1'b0; rd_req = 1'b0;

    // Wrap: 100 writes, each followed by a read, data returns in order
    for (int i = 0; i < 100; i++) begin
      rx_data = 8'(i);
      rd_req = (i != 0);
      tick();
      if (i != 0) begin
        chk("wrap_valid", 32'(rd_valid), 32'd1);
        chk("wrap_data", 32'(rd_data), 32'(i - 1));
      end
    end
    rx_valid = 1'b0;
    tick();
    chk("wrap_last_data", 32'(rd_data), 32'd99);
    chk("wrap_last_empty", 32'(rx_empty), 32'd1);
    rd_req = 1'b0;

    // Queue 5 characters, then reset discards them
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'hC0 + i);
      tick();
    end
    chk("q5_room", 32'(rxroom), 32'd59);
    rx_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst3_empty", 32'(rx_empty), 32'd1);
    chk("rst3_room", 32'(rxroom), 32'd63);
    chk("rst3_data", 32'(rd_data), 32'h000);
    rd_req = 1'b1;
    tick();
    chk("rst3_rd_valid", 32'(rd_valid), 32'd0);
    rd_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_spw_rx_fifo

// File: doc/spw_rx_fifo.md
Name: spw_rx_fifo

Overview:
Receive-side character buffer between the SpaceWire codec receiver and the CPU's PIO input ports. It queues each received N-Char (8-bit data plus control flag) from the codec and exports `rx_empty`, which the CPU polls as a single-bit PIO input. It also exports read data for a CPU-driven pop strobe and a free-space count the codec uses to issue FCT credits.

Parameters:
- DEPTH_LOG2, 6, log2 of FIFO depth in characters (default 64 entries).
- ROOM_W, 6, width of `rxroom`; free space is reported saturated at 2**ROOM_W-1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe from the codec: character present on `rx_flag`/`rx_data`.
- rx_flag  in  1  control flag (1 = EOP/EEP marker, 0 = data byte).
- rx_data  in  8  character payload; for a marker, bit 0 selects 0 = EOP, 1 = EEP.
- rd_req  in  1  pop request from the CPU-side PIO output, one-cycle pulse.
- rd_data  out  9  {flag, data} of the popped character.
- rd_valid  out  1  one-cycle pulse: `rd_data` updated.
- rx_empty  out  1  FIFO holds zero characters; feeds the CPU empty-flag PIO input.
- rx_full  out  1  FIFO holds 2**DEPTH_LOG2 characters.
- rxroom  out  ROOM_W  free entries, saturated at 2**ROOM_W-1; consumed by the codec credit logic.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.
- ovf_clr  in  1  one-cycle pulse: clears `overflow`.

Behaviour:
- Reset values: `rd_data`=0, `rd_valid`=0, `rx_empty`=1, `rx_full`=0, `rxroom`=min(2**DEPTH_LOG2, 2**ROOM_W-1), `overflow`=0. Read/write pointers and count are cleared. Memory contents are don't-care.
- Reset asserted mid-operation discards all queued characters in the same edge. Any `rd_req` or `rx_valid` coinciding with `reset` is ignored.
- Storage: circular buffer with DEPTH_LOG2-bit pointers that wrap naturally at 2**DEPTH_LOG2-1 to 0. Occupancy is held in a DEPTH_LOG2+1-bit count.
- Write: on `rx_valid` with not full, or full with an accepted read in the same cycle, store {`rx_flag`, `rx_data`} at the write pointer and increment it.
- Write when full and no read in the same cycle: the character is dropped, pointer and count are unchanged, and `overflow` is set on the next edge.
- Read: on `rd_req` with count>0, `rd_data` is loaded from the read pointer at the next edge, `rd_valid` pulses for 1 cycle, and the read pointer increments. Latency is 1 cycle from `rd_req` to `rd_valid`.
- Read when empty: ignored; `rd_valid` stays 0 and `rd_data` holds its previous value. A write in the same cycle does not satisfy that read (no fall-through).
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Status timing: `rx_empty`, `rx_full` and `rxroom` are registered. They reflect the count after the edge on which the write or read took effect, i.e. one cycle after the strobe.
- `rxroom` is recomputed from the next-state count, with no extra lag.
- Overflow precedence: `ovf_clr` and a new overflow in the same cycle leave `overflow`=1 (set wins).
- Back-to-back `rx_valid` every cycle is supported. Back-to-back `rd_req` every cycle is supported.

Optional Feature:
- SPW_RX_FIFO_DROP_CNT_EN: when defined, adds output port `drop_cnt` [15:0], a count of dropped characters.
  - Reset value is 0.
  - Increments on every dropped write and saturates at 16'hFFFF.
  - Cleared by `ovf_clr`; a simultaneous drop makes the result 1.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package `spw_pkg`:
  - SPW_CHAR_W=9.
  - Marker encodings: SPW_EOP=9'h100, SPW_EEP=9'h101.
  - The `spw_char_t` packed struct {flag, data[7:0]}.
- Sub-module `spw_rx_fifo_mem`: simple dual-port RAM, 2**DEPTH_LOG2 x 9, with synchronous write and registered synchronous read, suitable for an M9K. All pointer, count and status logic stays in `spw_rx_fifo`.

Test Plan:
- Reset, then write 3 characters (8'h41, 8'h42, EOP) -> `rx_empty` falls 1 cycle after the first `rx_valid`; `rxroom` reads 63, 62, 61.
- Pop 3 times -> `rd_data` = 9'h041, 9'h042, 9'h100, each with `rd_valid` 1 cycle after `rd_req`; `rx_empty`=1 after the third pop.
- Fill with 64 writes, then a 65th write of 8'hFF -> `rx_full`=1, `rxroom`=0, `overflow`=1, the 65th character is not stored; (with SPW_RX_FIFO_DROP_CNT_EN) `drop_cnt`=1.
- At full, assert `rx_valid` and `rd_req` together -> oldest character is returned, new character is accepted, count stays 64, `overflow` stays 0.
- `rd_req` while empty -> no `rd_valid`, `rd_data` unchanged; assert `ovf_clr` together with a drop -> `overflow` stays 1.
- Write 100 characters interleaved with reads to force pointer wrap past entry 63 -> data read in order 0..99; then assert `reset` with 5 characters queued -> `rx_empty`=1 and `rxroom`=63 on the next cycle.
